fifo_tx_sched: RTL and testbench
================================

FIFO_TX_SCHED -- requirements
Module: fifo_tx_sched

Interface
REQ-001 Parameter TX_GAP, default 2, idle cycles inserted after each transmitted byte (0 = none).
REQ-002 Parameter DEPTH, default 16, FIFO entry count.
REQ-003 clk  in  1  single clock, all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  block enable; gates new grants and new pops.
REQ-006 req_a / req_b  in  1 each  push request from requester A / B.
REQ-007 data_a / data_b  in  8 each  byte offered by requester A / B.
REQ-008 gnt_a / gnt_b  out  1 each  grant; the byte is consumed in the cycle gnt is high.
REQ-009 fifo_push  out  1  push strobe to FIFO.
REQ-010 fifo_din  out  8  byte to FIFO.
REQ-011 fifo_full  in  1  FIFO full flag.
REQ-012 fifo_pop  out  1  pop strobe to FIFO.
REQ-013 fifo_dout  in  8  FIFO head byte, valid combinationally before pop.
REQ-014 tx_ready  in  1  transmitter idle.
REQ-015 tx_start  out  1  one-cycle start pulse to transmitter.
REQ-016 tx_data  out  8  registered byte to transmitter.
REQ-017 level  out  5  block-tracked occupancy, 0..DEPTH.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The block SHALL track occupancy in level and SHALL NOT use the FIFO empty flag, because that flag is not valid after reset.
REQ-020 Grant is combinational and requires en=1, fifo_full=0 and level<DEPTH; when granted, fifo_push=1 and fifo_din=data of the winner in the same cycle.
REQ-021 Arbitration is two-way round-robin: if one requester is active, it wins; if both are active, the requester not granted last wins; after reset A has priority.
REQ-022 At most one gnt SHALL be high per cycle; the round-robin pointer updates only on a grant.
REQ-023 On push without pop, level increments by 1; on pop without push, it decrements by 1; on both, it is unchanged; level SHALL never wrap past 0 or DEPTH.
REQ-024 FSM states are IDLE, SEND, WAIT, GAP.
REQ-025 IDLE -> SEND when en=1, level!=0 and tx_ready=1; in that cycle, assert fifo_pop=1 for one cycle and register tx_data<=fifo_dout.
REQ-026 SEND: assert tx_start=1 for exactly one cycle, then go to WAIT.
REQ-027 WAIT: hold until tx_ready=1, which is sampled no earlier than the cycle after SEND; then go to GAP if TX_GAP>0, else to IDLE.
REQ-028 GAP: a 4-bit counter counts TX_GAP cycles, then the FSM goes to IDLE.
REQ-029 Pop-to-tx_start latency is 1 cycle; the minimum byte period is 3+TX_GAP cycles.
REQ-030 A simultaneous push and pop in one cycle is legal; a push granted in the same cycle as a pop at level=0 is not possible because no pop is issued at level=0.
REQ-031 If en drops mid-byte, the current byte completes through WAIT and GAP; no new grant or pop is issued while en=0.
REQ-032 While level=DEPTH or fifo_full=1, requests stall with no grant; the block never drops data and never causes FIFO overrun or underrun.

Reset
REQ-033 When rst=0 at posedge clk, the following take effect in that cycle: state=IDLE, level=0, gap counter=0, round-robin pointer=A, tx_data=0, and gnt_a, gnt_b, fifo_push, fifo_pop, tx_start and busy all low.
REQ-034 Reset mid-byte SHALL abort the sequence immediately; the FIFO is reset alongside the block, so no level resynchronisation is required.

Structure
REQ-035 Package fifo_sched_pkg SHALL hold the state enum, DATA_W=8 and DEPTH_DEF=16.
REQ-036 The two-way round-robin arbiter SHALL be a sub-module rr_arb2 (req[1:0] in, gnt[1:0] out, pointer internal).
REQ-037 The FSM, gap counter and level counter reside in fifo_tx_sched.

Verification
REQ-038 Reset, then req_a=1 with data_a=8'h41 for 1 cycle and tx_ready=1 -> gnt_a and fifo_push in that cycle; level goes 0->1; fifo_pop follows; tx_start one cycle later with tx_data=8'h41.
REQ-039 With req_a=req_b=1 held and tx_ready=0 -> grants alternate A,B,A,B...; after 16 grants level=16 and no further gnt until a pop.
REQ-040 With TX_GAP=2 and 3 bytes queued, tx_ready returning 2 cycles after each tx_start -> tx_start pulses spaced exactly 1+2+1+2=6 cycles apart, bytes in push order.
REQ-041 Push and pop in the same cycle at level=5 -> level stays 5 and the round-robin pointer advances.
REQ-042 Drop en during WAIT with level=4 -> the current byte finishes, there are no pops or grants while en=0, and popping resumes within 1 cycle of en=1.
REQ-043 Assert rst=0 in SEND -> the next cycle has tx_start=0, busy=0, level=0 and state=IDLE.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO-fed transmit scheduler.
package fifo_sched_pkg;

  localparam int DATA_W    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int LEVEL_W   = 5;
  localparam int GAP_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set when B holds priority for the next contested cycle.
  logic prio_b_q;
  logic prio_b_d;

  always_comb begin
    gnt      = 2'b00;
    prio_b_d = prio_b_q;
    if (req[0] && (!req[1] || !prio_b_q)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
    if (gnt[0]) begin
      prio_b_d = 1'b1;
    end else if (gnt[1]) begin
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/fifo_tx_sched.sv
// Arbitrates two byte requesters into an external FIFO and paces FIFO bytes
// out to a transmitter with a fixed idle gap after each byte.
module fifo_tx_sched
  import fifo_sched_pkg::*;
#(
  parameter int TX_GAP = 2,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               req_a,
  input  logic               req_b,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [DATA_W-1:0]  data_b,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic               fifo_push,
  output logic [DATA_W-1:0]  fifo_din,
  input  logic               fifo_full,
  output logic               fifo_pop,
  input  logic [DATA_W-1:0]  fifo_dout,
  input  logic               tx_ready,
  output logic               tx_start,
  output logic [DATA_W-1:0]  tx_data,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output state_t             dbg_state
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(DEPTH);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((TX_GAP > 0) ? TX_GAP - 1 : 0);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               can_push;
  logic [1:0]         arb_req;
  logic [1:0]         arb_gnt;
  logic               pop;

  // Handshake: req_x/data_x is an offer held by the requester and is consumed
  // only in a cycle where gnt_x is high; fifo_push/fifo_din mirror that grant.
  assign can_push = rst && en && !fifo_full && (level_q < LEVEL_MAX);
  assign arb_req  = can_push ? {req_b, req_a} : 2'b00;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  assign gnt_a     = arb_gnt[0];
  assign gnt_b     = arb_gnt[1];
  assign fifo_push = |arb_gnt;
  assign fifo_din  = arb_gnt[1] ? data_b : (arb_gnt[0] ? data_a : '0);

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst && en && (level_q != '0) && tx_ready) begin
          pop       = 1'b1;
          tx_data_d = fifo_dout;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_ready) begin
          gap_cnt_d = '0;
          state_d   = (TX_GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy is tracked here because the FIFO empty flag is unreliable after reset.
  always_comb begin
    level_d = level_q;
    if (fifo_push && !pop && (level_q != LEVEL_MAX)) begin
      level_d = level_q + 1'b1;
    end else if (pop && !fifo_push && (level_q != '0)) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      gap_cnt_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      gap_cnt_q <= gap_cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign fifo_pop  = pop;
  assign tx_start  = (state_q == ST_SEND);
  assign tx_data   = tx_data_q;
  assign level     = level_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_tx_sched.sv
// Directed bench for fifo_tx_sched with a FIFO model, a transmitter model and
// an expected-byte scoreboard on tx_start.
module tb_fifo_tx_sched;
  import fifo_sched_pkg::*;

  localparam int TX_GAP = 2;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b;
  logic       fifo_push;
  logic [7:0] fifo_din;
  logic       fifo_full;
  logic       fifo_pop;
  logic [7:0] fifo_dout = 8'h00;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic       busy;
  state_t     dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem_q[$];
  int         start_t[$];

  logic tx_auto      = 1'b0;
  logic tx_ready_man = 1'b0;
  int   busy_cnt     = 0;

  logic       s_rst  = 1'b0;
  logic       s_pop  = 1'b0;
  logic       s_push = 1'b0;
  logic       s_start = 1'b0;
  logic [7:0] s_din  = 8'h00;

  typedef struct {
    logic       en;
    logic       ra;
    logic       rb;
    logic       full;
    logic       ega;
    logic       egb;
    logic [4:0] elevel;
  } vec_t;

  vec_t vecs[10];

  assign tx_ready = tx_auto ? (busy_cnt == 0) : tx_ready_man;

  fifo_tx_sched #(.TX_GAP(TX_GAP), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_a     (req_a),
    .req_b     (req_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .fifo_pop  (fifo_pop),
    .fifo_dout (fifo_dout),
    .tx_ready  (tx_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .level     (level),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and strobe capture, away from the active edge.
  always @(negedge clk) begin
    s_rst   <= rst;
    s_pop   <= fifo_pop;
    s_push  <= fifo_push;
    s_din   <= fifo_din;
    s_start <= tx_start;
    if (tx_start) begin
      start_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL tx_unexpected: got %0h expected none", tx_data);
      end else begin
        chk("tx_data_order", tx_data, exp_q.pop_front());
      end
    end
  end

  // FIFO and transmitter models, committing the strobes captured above.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!s_rst) begin
      mem_q.delete();
      busy_cnt <= 0;
    end else begin
      if (s_pop) begin
        if (mem_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL fifo_underrun: got pop expected none");
        end else begin
          void'(mem_q.pop_front());
        end
      end
      if (s_push) begin
        if (mem_q.size() >= DEPTH) begin
          n_total++;
          n_bad++;
          $display("FAIL fifo_overrun: got push expected none");
        end
        mem_q.push_back(s_din);
      end
      if (s_start) busy_cnt <= 1;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    fifo_dout <= (mem_q.size() != 0) ? mem_q[0] : 8'h00;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; req_a = 1'b0; req_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; fifo_full = 1'b0;
    tx_auto = 1'b0; tx_ready_man = 1'b0;
    tick();
    tick();
    exp_q.delete();
    start_t.delete();
    rst = 1'b1;
  endtask

  task automatic push_a(input logic [7:0] d);
    req_a = 1'b1;
    data_a = d;
    settle();
    chk("push_a_gnt", gnt_a, 1'b1);
    exp_q.push_back(d);
    tick();
    req_a = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    n_total++;
    if (exp_q.size() != 0 || busy) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d bytes left busy=%0b expected 0", name, exp_q.size(), busy);
    end
    chk({name, "_level"}, level, 5'd0);
  endtask

  initial begin
    int viol;
    int k;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7};

    // Reset state.
    do_reset();
    settle();
    chk("rst_level", level, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_gnt", {gnt_a, gnt_b}, 2'b00);
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);

    // Single byte A path.
    tx_auto = 1'b1;
    req_a = 1'b1;
    data_a = 8'h41;
    settle();
    chk("a1_gnt_a", gnt_a, 1'b1);
    chk("a1_push", fifo_push, 1'b1);
    chk("a1_din", fifo_din, 8'h41);
    chk("a1_no_pop_lvl0", fifo_pop, 1'b0);
    exp_q.push_back(8'h41);
    tick();
    req_a = 1'b0;
    settle();
    chk("a1_level", level, 5'd1);
    chk("a1_pop", fifo_pop, 1'b1);
    tick();
    settle();
    chk("a1_tx_start", tx_start, 1'b1);
    chk("a1_tx_data", tx_data, 8'h41);
    wait_drain("a1", 50);

    // Table-driven grant vectors with the transmitter held busy.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en;
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      fifo_full = vecs[i].full;
      data_a = 8'h10 + 8'(i);
      data_b = 8'h80 + 8'(i);
      settle();
      chk($sformatf("v%0d_gnt_a", i), gnt_a, vecs[i].ega);
      chk($sformatf("v%0d_gnt_b", i), gnt_b, vecs[i].egb);
      chk($sformatf("v%0d_push", i), fifo_push, vecs[i].ega | vecs[i].egb);
      if (vecs[i].ega | vecs[i].egb) begin
        chk($sformatf("v%0d_din", i), fifo_din, vecs[i].ega ? data_a : data_b);
        exp_q.push_back(vecs[i].ega ? data_a : data_b);
      end
      tick();
      chk($sformatf("v%0d_level", i), level, vecs[i].elevel);
    end
    req_a = 1'b0; req_b = 1'b0; fifo_full = 1'b0; en = 1'b1;
    tx_auto = 1'b1;
    wait_drain("vec", 200);

    // Both requesters held: strict alternation until the FIFO is full.
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 8'hAA; data_b = 8'hBB;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk($sformatf("alt%0d_gnt_a", i), gnt_a, (i % 2) == 0);
      chk($sformatf("alt%0d_gnt_b", i), gnt_b, (i % 2) == 1);
      exp_q.push_back(((i % 2) == 0) ? 8'hAA : 8'hBB);
      tick();
    end
    chk("full_level", level, 5'd16);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("full%0d_no_gnt", i), {gnt_a, gnt_b, fifo_push}, 3'b000);
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    tx_auto = 1'b1;
    wait_drain("alt", 300);

    // Byte pacing with TX_GAP=2: tx_start every 6 cycles.
    do_reset();
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    start_t.delete();
    tx_auto = 1'b1;
    k = 0;
    while (start_t.size() < 3 && k < 60) begin
      tick();
      k++;
    end
    if (start_t.size() >= 3) begin
      chk("pace_gap1", start_t[1] - start_t[0], 6);
      chk("pace_gap2", start_t[2] - start_t[1], 6);
    end else begin
      n_total++;
      n_bad++;
      $display("FAIL pace_timeout: got %0d starts expected 3", start_t.size());
    end
    wait_drain("pace", 50);

    // Simultaneous push and pop at level 5.
    do_reset();
    for (int i = 0; i < 5; i++) push_a(8'h50 + 8'(i));
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h5A; data_b = 8'h5B;
    tx_ready_man = 1'b1;
    settle();
    chk("pp_pop", fifo_pop, 1'b1);
    chk("pp_gnt_b", gnt_b, 1'b1);
    chk("pp_gnt_a", gnt_a, 1'b0);
    exp_q.push_back(8'h5B);
    tick();
    tx_ready_man = 1'b0;
    settle();
    chk("pp_level", level, 5'd5);
    chk("pp_next_gnt_a", gnt_a, 1'b1);
    exp_q.push_back(8'h5A);
    tick();
    req_a = 1'b0; req_b = 1'b0;
    chk("pp_level6", level, 5'd6);
    tx_auto = 1'b1;
    wait_drain("pp", 100);

    // en dropped during WAIT with level 4.
    do_reset();
    for (int i = 0; i < 5; i++) push_a(8'h60 + 8'(i));
    tx_ready_man = 1'b1;
    settle();
    chk("en_first_pop", fifo_pop, 1'b1);
    tick();
    tx_ready_man = 1'b0;
    settle();
    chk("en_send", tx_start, 1'b1);
    tick();
    en = 1'b0;
    settle();
    chk("en_wait_level", level, 5'd4);
    chk("en_wait_state", dbg_state, ST_WAIT);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      req_a = 1'b1;
      data_a = 8'h6F;
      tx_ready_man = (i >= 2);
      settle();
      if (gnt_a || gnt_b || fifo_pop) viol++;
      tick();
    end
    chk("en0_activity", viol, 0);
    chk("en0_busy", busy, 1'b0);
    chk("en0_level", level, 5'd4);
    req_a = 1'b0;
    en = 1'b1;
    settle();
    chk("en1_pop", fifo_pop, 1'b1);
    tick();
    tx_auto = 1'b1;
    wait_drain("en", 100);

    // Reset asserted while in SEND.
    do_reset();
    push_a(8'h77);
    tx_ready_man = 1'b1;
    settle();
    chk("rs_pop", fifo_pop, 1'b1);
    tick();
    settle();
    chk("rs_send", dbg_state, ST_SEND);
    rst = 1'b0;
    req_a = 1'b1;
    settle();
    chk("rs_gnt_in_reset", gnt_a, 1'b0);
    tick();
    settle();
    chk("rs_tx_start", tx_start, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_level", level, 5'd0);
    chk("rs_state", dbg_state, ST_IDLE);
    chk("rs_tx_data", tx_data, 8'h00);
    rst = 1'b1;
    req_a = 1'b0;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
